// File: rtl/iram_pipe.sv
// Instruction memory for the fetch path: valid/ready request/response, byte addressing,
// LATENCY-cycle read pipeline with a fall-through response buffer. Optional IRAM_STATS_EN adds counters.
module iram_pipe #(
    parameter int    DATAWIDTH     = 32,
    parameter int    ADDRWIDTH     = 10,
    parameter int    LATENCY       = 1,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_data_o,
    output logic [1:0]           rsp_err_o,
`ifdef IRAM_STATS_EN
    output logic [31:0]          stat_fetch_o,
    output logic [31:0]          stat_stall_o,
`endif
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [ADDRWIDTH-1:0] wr_addr_i,
    input  logic [DATAWIDTH-1:0] wr_data_i
);

    localparam int OFFW  = $clog2(DATAWIDTH / 8);
    localparam int DEPTH = LATENCY + 1;
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int WORDS = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [WORDS];

    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [CNTW-1:0]      fcnt_q, fcnt_d;
    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [DATAWIDTH-1:0] dat_q [LATENCY];
    logic [1:0]           err_q [LATENCY];
    logic [DATAWIDTH-1:0] fdat_q [DEPTH];
    logic [DATAWIDTH-1:0] fdat_d [DEPTH];
    logic [1:0]           ferr_q [DEPTH];
    logic [1:0]           ferr_d [DEPTH];

    logic                 accept, misal, oor, pop, push, fpop, fifo_empty;
    logic [ADDRWIDTH-1:0] rd_idx;
    logic                 s_vld;
    logic [1:0]           s_err, hd_err;
    logic [DATAWIDTH-1:0] s_dat, hd_dat;

    assign misal       = |req_addr_i[OFFW-1:0];
    assign oor         = (req_addr_i >> (ADDRWIDTH + OFFW)) != 32'd0;
    assign rd_idx      = req_addr_i[OFFW +: ADDRWIDTH];
    assign req_ready_o = !wr_en_i && !flush_i && (cnt_q < CNTW'(DEPTH));
    assign accept      = req_valid_i && req_ready_o;

    // Stage 1 is the registered array read; later stages are plain delay registers
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (accept) begin
            dat_q[0] <= mem[rd_idx];
            err_q[0] <= {oor, misal};
        end
        for (int k = 1; k < LATENCY; k++) begin
            dat_q[k] <= dat_q[k-1];
            err_q[k] <= err_q[k-1];
        end
        fdat_q <= fdat_d;
        ferr_q <= ferr_d;
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept;
        for (int k = 1; k < LATENCY; k++) vld_d[k] = vld_q[k-1];
    end

    // Last pipeline stage feeds the buffer; faulted words are forced to zero here
    assign s_vld      = vld_q[LATENCY-1];
    assign s_err      = err_q[LATENCY-1];
    assign s_dat      = (s_err != 2'b00) ? '0 : dat_q[LATENCY-1];
    assign fifo_empty = (fcnt_q == '0);

    always_comb begin
        hd_dat = s_dat;
        hd_err = s_err;
        if (!fifo_empty) begin
            hd_dat = fdat_q[0];
            hd_err = ferr_q[0];
        end
    end

    assign rsp_valid_o = !fifo_empty || s_vld;
    assign rsp_data_o  = rsp_valid_o ? hd_dat : '0;
    assign rsp_err_o   = rsp_valid_o ? hd_err : 2'b00;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign fpop        = pop && !fifo_empty;
    assign push        = s_vld && !(fifo_empty && rsp_ready_i);

    always_comb begin
        fdat_d = fdat_q;
        ferr_d = ferr_q;
        fcnt_d = fcnt_q;
        if (fpop) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                fdat_d[k] = fdat_q[k+1];
                ferr_d[k] = ferr_q[k+1];
            end
            fcnt_d = fcnt_q - CNTW'(1);
        end
        if (push) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k == int'(fcnt_d)) begin
                    fdat_d[k] = s_dat;
                    ferr_d[k] = s_err;
                end
            end
            fcnt_d = fcnt_d + CNTW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q + CNTW'(1);
        else if (!accept && pop) cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            cnt_q  <= '0;
            fcnt_q <= '0;
        end else if (flush_i) begin
            vld_q  <= '0;
            cnt_q  <= '0;
            fcnt_q <= '0;
        end else begin
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
        end
    end

`ifdef IRAM_STATS_EN
    logic [31:0] fetch_q, stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (accept)                      fetch_q <= fetch_q + 32'd1;
            if (req_valid_i && !req_ready_o) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_fetch_o = fetch_q;
    assign stat_stall_o = stall_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_iram_pipe.sv
// Bench for iram_pipe (LATENCY=2): a queue-based response model checked every cycle plus directed literal checks.
module tb_iram_pipe;
    localparam int L  = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [31:0]   req_addr_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_data_o;
    logic [1:0]    rsp_err_o;
    logic          flush_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic [DW-1:0] wr_data_i = '0;
`ifdef IRAM_STATS_EN
    logic [31:0]   stat_fetch_o, stat_stall_o;
`endif

    iram_pipe #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LATENCY(L)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
`ifdef IRAM_STATS_EN
        .stat_fetch_o(stat_fetch_o), .stat_stall_o(stat_stall_o),
`endif
        .flush_i(flush_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [1024];
    int          cyc = 0;

    initial for (int i = 0; i < 1024; i++) mm[i] = '0;

    always @(negedge clk) begin
        logic        eready, evalid;
        logic [31:0] edata;
        logic [1:0]  eerr;
        rsp_t        r;
        if (!rst_ni) begin
            q.delete();
            chk("mon_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
            chk("mon_rst_data", rsp_data_o, 32'd0);
            chk("mon_rst_err", {30'd0, rsp_err_o}, 32'd0);
        end else begin
            eready = !wr_en_i && !flush_i && (q.size() < L + 1);
            evalid = (q.size() > 0) && (q[0].due <= cyc);
            edata  = evalid ? q[0].data : 32'd0;
            eerr   = evalid ? q[0].err : 2'b00;
            chk("mon_req_ready", {31'd0, req_ready_o}, {31'd0, eready});
            chk("mon_rsp_valid", {31'd0, rsp_valid_o}, {31'd0, evalid});
            chk("mon_rsp_data", rsp_data_o, edata);
            chk("mon_rsp_err", {30'd0, rsp_err_o}, {30'd0, eerr});
            if (evalid && rsp_ready_i) void'(q.pop_front());
            if (flush_i) q.delete();
            if (req_valid_i && eready) begin
                r.err[0] = (req_addr_i[1:0] != 2'b00);
                r.err[1] = (req_addr_i[31:12] != 20'd0);
                r.data   = (r.err != 2'b00) ? 32'd0 : mm[req_addr_i[11:2]];
                r.due    = cyc + L;
                q.push_back(r);
            end
            if (wr_en_i) mm[wr_addr_i] = wr_data_i;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words [4];
    logic [31:0] faddr [3];
    logic [1:0]  ferr  [3];
    int          acc;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        words[0] = 32'h00000013; words[1] = 32'h00100093;
        words[2] = 32'h00200113; words[3] = 32'h00300193;
        faddr[0] = 32'h00000006; faddr[1] = 32'h00001000; faddr[2] = 32'h00001002;
        ferr[0]  = 2'b01;        ferr[1]  = 2'b10;        ferr[2]  = 2'b11;

        repeat (2) step();
        chk("reset_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("reset_data", rsp_data_o, 32'd0);
        chk("reset_err", {30'd0, rsp_err_o}, 32'd0);
        rst_ni = 1'b1;
        step();

        // Loader writes words 0..3
        for (int i = 0; i < 4; i++) begin
            wr_en_i = 1'b1; wr_addr_i = AW'(i); wr_data_i = words[i];
            req_valid_i = 1'b1; req_addr_i = 32'h0;
            #1 chk("load_blocks_ready", {31'd0, req_ready_o}, 32'd0);
            step();
        end
        wr_en_i = 1'b0; req_valid_i = 1'b0;
        step();

        // Back-to-back reads with the consumer always ready
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = (i < 4);
            req_addr_i  = 32'(4 * i);
            #1;
            if (i < 4) chk("b2b_ready", {31'd0, req_ready_o}, 32'd1);
            if (i >= 2) begin
                chk("b2b_valid", {31'd0, rsp_valid_o}, 32'd1);
                chk("b2b_data", rsp_data_o, words[i-2]);
                chk("b2b_err", {30'd0, rsp_err_o}, 32'd0);
            end
            step();
        end
        req_valid_i = 1'b0;
        #1 chk("b2b_drained", {31'd0, rsp_valid_o}, 32'd0);
        step();

        // Back-pressure: only LATENCY+1 requests may be outstanding
        rsp_ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 32'(4 * acc);
            #1;
            if (req_ready_o) acc++;
            step();
        end
        req_valid_i = 1'b0;
        chk("bp_accepts", 32'(acc), 32'd3);
        #1 chk("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
        repeat (3) step();
        chk("bp_hold_data", rsp_data_o, words[0]);
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_data", rsp_data_o, words[i]);
            step();
        end
        #1 chk("bp_drained", {31'd0, rsp_valid_o}, 32'd0);
        step();

        // Alignment and range faults
        for (int i = 0; i < 5; i++) begin
            req_valid_i = (i < 3);
            req_addr_i  = (i < 3) ? faddr[i] : 32'h0;
            #1;
            if (i >= 2) begin
                chk("fault_valid", {31'd0, rsp_valid_o}, 32'd1);
                chk("fault_data", rsp_data_o, 32'd0);
                chk("fault_err", {30'd0, rsp_err_o}, {30'd0, ferr[i-2]});
            end
            step();
        end
        req_valid_i = 1'b0;
        step();

        // Flush with responses buffered and in flight
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 32'(4 * i);
            #1 chk("flush_pre_ready", {31'd0, req_ready_o}, 32'd1);
            step();
        end
        req_valid_i = 1'b0;
        flush_i = 1'b1;
        #1 chk("flush_blocks_ready", {31'd0, req_ready_o}, 32'd0);
        chk("flush_pre_valid", {31'd0, rsp_valid_o}, 32'd1);
        step();
        flush_i = 1'b0;
        #1 chk("flush_valid_low", {31'd0, rsp_valid_o}, 32'd0);
        chk("flush_ready_back", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1; req_addr_i = 32'h4;
        step();
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        step();
        chk("flush_after_data", rsp_data_o, 32'h00100093);
        step();

        // Write then read of the same word
        wr_en_i = 1'b1; wr_addr_i = AW'(5); wr_data_i = 32'hDEADBEEF;
        req_valid_i = 1'b1; req_addr_i = 32'h14;
        #1 chk("wr_cycle_ready", {31'd0, req_ready_o}, 32'd0);
        step();
        wr_en_i = 1'b0;
        #1 chk("wr_next_ready", {31'd0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        step();
        chk("wr_read_data", rsp_data_o, 32'hDEADBEEF);
        step();

        // Write and flush in the same cycle both take effect
        wr_en_i = 1'b1; flush_i = 1'b1; wr_addr_i = AW'(6); wr_data_i = 32'h00600313;
        step();
        wr_en_i = 1'b0; flush_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 32'h18;
        step();
        req_valid_i = 1'b0;
        step();
        chk("wrflush_data", rsp_data_o, 32'h00600313);
        step();

        // Asynchronous reset with responses pending
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 32'h8;
        step();
        req_addr_i = 32'hC;
        step();
        req_valid_i = 1'b0;
        step();
        chk("rst_pre_valid", {31'd0, rsp_valid_o}, 32'd1);
        rst_ni = 1'b0;
        #1 chk("rst_async_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_async_data", rsp_data_o, 32'd0);
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_addr_i = 32'h0;
        step();
        req_valid_i = 1'b0;
        step();
        chk("rst_mem_intact", rsp_data_o, 32'h00000013);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
